axi4_lite_lsu_master: RTL and testbench

//  Data-side AXI4-Lite master for the MEM stage. Converts one load or store into one AXI4-Lite

---
 rtl/axi4_lite_lsu_master.sv | 167 ++++++++++++++++
 tb/tb_axi4_lite_lsu_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_lsu_master.sv
// Data-side AXI4-Lite master for the MEM stage: one load or store becomes one AXI4-Lite
// transaction, with a combinational stall to the hazard unit while it is outstanding.
//
// state | meaning
// IDLE  | waiting for a load/store request
// WADDR | AW and W beats outstanding, each may complete independently
// WRESP | waiting for the write response
// RADDR | AR beat outstanding
// RDATA | waiting for the read data beat
// DONE  | result valid for one cycle, pipeline released
module axi4_lite_lsu_master #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    axi_err,
    output logic                    stall_axi,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic [ADDR_WIDTH-1:0]     r_araddr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic [DATA_WIDTH-1:0]     r_mem_rdata;
    logic                      r_axi_err;

    logic w_req;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_ok;
    logic w_w_ok;

    assign w_req   = mem_read | mem_write;
    assign w_aw_hs = r_awvalid & m_axi_awready;
    assign w_w_hs  = r_wvalid & m_axi_wready;
    // A channel counts as complete if it finished earlier or is handshaking right now.
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | w_w_hs;

    assign stall_axi = w_req & (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_mem_rdata <= '0;
            r_axi_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_write) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_awaddr  <= mem_addr;
                        r_wdata   <= mem_wdata;
                        r_wstrb   <= mem_wstrb;
                        r_state   <= S_WADDR;
                    end else if (mem_read) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= mem_addr;
                        r_state   <= S_RADDR;
                    end
                end
                S_WADDR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        r_axi_err <= (m_axi_bresp != 2'b00);
                        r_state   <= S_DONE;
                    end
                end
                S_RADDR: begin
                    if (r_arvalid && m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        r_mem_rdata <= m_axi_rdata;
                        r_axi_err   <= (m_axi_rresp != 2'b00);
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The request is still present here; returning to IDLE keeps it from re-issuing.
                    r_axi_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rdata     = r_mem_rdata;
    assign axi_err       = r_axi_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == S_WRESP);
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = (r_state == S_RDATA);

endmodule

// File: tb/tb_axi4_lite_lsu_master.sv
// Scoreboard bench for axi4_lite_lsu_master: a configurable-latency AXI4-Lite slave,
// expected beats/results queued by the driver and popped by negedge monitors.
module tb_axi4_lite_lsu_master;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        axi_err, stall_axi;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axi4_lite_lsu_master dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .axi_err(axi_err), .stall_axi(stall_axi),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_ar[$];
    done_t       exp_done[$];

    int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // slave model and channel protocol checks
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_pend, w_pend, ar_pend;
    bit          b_taken, r_taken;
    bit          p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs;
    logic [31:0] p_awaddr, p_araddr;
    logic [35:0] p_w;

    always @(negedge clk) begin
        if (rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0;
            m_axi_rdata = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0; b_taken = 0; r_taken = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_awhs = 0; p_whs = 0; p_arhs = 0;
        end else begin
            if (p_awhs) chk("aw_drop", m_axi_awvalid, 0);
            else if (p_awv) begin
                chk("aw_hold", m_axi_awvalid, 1);
                chk("aw_stable", m_axi_awaddr, p_awaddr);
            end
            if (p_whs) chk("w_drop", m_axi_wvalid, 0);
            else if (p_wv) begin
                chk("w_hold", m_axi_wvalid, 1);
                chk("w_stable", {m_axi_wstrb, m_axi_wdata}, p_w);
            end
            if (p_arhs) chk("ar_drop", m_axi_arvalid, 0);
            else if (p_arv) begin
                chk("ar_hold", m_axi_arvalid, 1);
                chk("ar_stable", m_axi_araddr, p_araddr);
            end
            if (m_axi_bready) chk("wresp_after_both", m_axi_awvalid | m_axi_wvalid, 0);
            if (m_axi_rready) chk("rdata_after_ar", m_axi_arvalid, 0);

            if (b_taken) begin m_axi_bvalid = 0; b_taken = 0; end
            if (!m_axi_bvalid && aw_pend > 0 && w_pend > 0) begin
                if (b_cnt == cfg_b) begin
                    m_axi_bvalid = 1; m_axi_bresp = cfg_resp;
                    aw_pend--; w_pend--; b_cnt = 0;
                end else b_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) b_taken = 1;

            if (r_taken) begin m_axi_rvalid = 0; r_taken = 0; end
            if (!m_axi_rvalid && ar_pend > 0) begin
                if (r_cnt == cfg_r) begin
                    m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rdata = cfg_rdata;
                    ar_pend--; r_cnt = 0;
                end else r_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready) r_taken = 1;

            if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == cfg_aw); aw_cnt++; end
            else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_cnt == cfg_w); w_cnt++; end
            else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == cfg_ar); ar_cnt++; end
            else begin m_axi_arready = 0; ar_cnt = 0; end

            p_awhs = m_axi_awvalid && m_axi_awready;
            p_whs  = m_axi_wvalid && m_axi_wready;
            p_arhs = m_axi_arvalid && m_axi_arready;
            if (p_awhs) begin
                chk("aw_expected", exp_aw.size() > 0, 1);
                if (exp_aw.size() > 0) chk("aw_addr", m_axi_awaddr, exp_aw.pop_front());
                chk("aw_prot", m_axi_awprot, 3'b000);
                aw_pend++;
            end
            if (p_whs) begin
                chk("w_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) chk("w_data_strb", {m_axi_wstrb, m_axi_wdata}, exp_w.pop_front());
                w_pend++;
            end
            if (p_arhs) begin
                chk("ar_expected", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) chk("ar_addr", m_axi_araddr, exp_ar.pop_front());
                chk("ar_prot", m_axi_arprot, 3'b000);
                ar_pend++;
            end
            p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid;  p_w = {m_axi_wstrb, m_axi_wdata};
            p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
        end
    end

    // result monitor: the DONE cycle is the one where a request is present but not stalled
    int  stall_cnt;
    bit  prev_done;
    done_t d;

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0; prev_done = 0;
        end else begin
            if (prev_done) chk("err_clear_after_done", axi_err, 0);
            prev_done = 0;
            if (stall_axi) stall_cnt++;
            if (!(mem_read || mem_write)) chk("stall_no_req", stall_axi, 0);
            else if (!stall_axi) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    if (d.is_load) chk("mem_rdata", mem_rdata, d.rdata);
                    chk("axi_err", axi_err, d.err);
                    chk("stall_cycles", stall_cnt, d.stall);
                end
                stall_cnt = 0; prev_done = 1; done_cnt++;
            end
        end
    end

    // kind: 0 load, 1 store, 2 load+store (write wins)
    task automatic run_vec(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int aw, input int w, input int b,
                           input int ar, input int r, input logic [1:0] resp,
                           input logic [31:0] rdata, input logic exp_err, input int exp_stall,
                           input int gap);
        done_t e;
        int start;
        int t;
        cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r;
        cfg_resp = resp; cfg_rdata = rdata;
        e.is_load = (kind == 0); e.rdata = rdata; e.err = exp_err; e.stall = exp_stall;
        if (kind == 0) exp_ar.push_back(addr);
        else begin
            exp_aw.push_back(addr);
            exp_w.push_back({wstrb, wdata});
        end
        exp_done.push_back(e);
        mem_read  = (kind != 1);
        mem_write = (kind != 0);
        mem_addr  = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("done_timeout", done_cnt != start, 1);
        #1;
        if (gap > 0) begin
            mem_read = 0; mem_write = 0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t;
        rst = 1; mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 0; cfg_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids_readies", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_axi_err", axi_err, 0);
        chk("rst_stall", stall_axi, 0);
        rst = 0;
        @(posedge clk); #1;

        //      kind addr          wdata         strb    aw w  b  ar r  resp   rdata        err stall gap
        run_vec(1, 32'h8000_0010, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 3, 2);
        run_vec(0, 32'h8000_0020, 32'h0,        4'b0000, 0, 0, 0, 2, 2, 2'b00, 32'h12345678, 0, 7, 2);
        run_vec(1, 32'h8000_0030, 32'hAAAA5555, 4'b1111, 0, 4, 0, 0, 0, 2'b00, 32'h0,        0, 7, 1);
        run_vec(1, 32'h8000_0034, 32'h0F0F0F0F, 4'b1100, 4, 0, 1, 0, 0, 2'b00, 32'h0,        0, 8, 1);
        run_vec(0, 32'h8000_0040, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b10, 32'hCAFEF00D, 1, 3, 2);
        run_vec(0, 32'h8000_0050, 32'h0,        4'b0000, 0, 0, 0, 0, 1, 2'b00, 32'h0BADC0DE, 0, 4, 0);
        run_vec(1, 32'h8000_0054, 32'h11223344, 4'b1111, 1, 0, 0, 0, 0, 2'b00, 32'h0,        0, 4, 2);
        run_vec(1, 32'h8000_0058, 32'h55667788, 4'b0100, 0, 0, 0, 0, 0, 2'b11, 32'h0,        1, 3, 1);
        run_vec(2, 32'h8000_0060, 32'h99AABBCC, 4'b1000, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 3, 2);

        // reset while waiting in RDATA
        cfg_ar = 0; cfg_r = 30; cfg_resp = 0; cfg_rdata = 32'hFFFF0000;
        exp_ar.push_back(32'h8000_0070);
        mem_read = 1; mem_write = 0; mem_addr = 32'h8000_0070;
        t = 0;
        while (!m_axi_rready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_rdata", m_axi_rready, 1);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("midrst_valids_readies", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        chk("midrst_stall_req", stall_axi, 1);
        chk("midrst_mem_rdata", mem_rdata, 0);
        mem_read = 0;
        #1;
        chk("midrst_stall_noreq", stall_axi, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        run_vec(0, 32'h8000_0080, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'h55AA33CC, 0, 3, 3);

        chk("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
